vga_scanout: RTL

- Parametrised, single-clock successor to the existing VGA timing/scan-out logic.
- Generates programmable H/V timing with frame-synchronous configuration load.
- Unpacks DATA_W-bit words from a first-word-fall-through pixel FIFO at 1/8/16/32 bpp into 24-bit RGB.
- Issues per-line fetch requests to the memory-side requester, and flags FIFO underflow.
- Sits entirely in the vga_clk domain, between the pixel FIFO read port and the VGA pins.

---
 rtl/vga_scanout.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// VGA timing generator and pixel unpacker: programmable H/V timing with frame-synchronous
// configuration load, FWFT FIFO scan-out at 1/8/16/32 bpp, per-line fetch requests.
module vga_scanout #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 12
) (
  input  logic              vga_clk,
  input  logic              vga_reset_n,
  input  logic [CNT_W-1:0]  cfg_h_total,
  input  logic [CNT_W-1:0]  cfg_h_sync,
  input  logic [CNT_W-1:0]  cfg_h_start,
  input  logic [CNT_W-1:0]  cfg_h_width,
  input  logic [CNT_W-1:0]  cfg_v_total,
  input  logic [CNT_W-1:0]  cfg_v_sync,
  input  logic [CNT_W-1:0]  cfg_v_start,
  input  logic [CNT_W-1:0]  cfg_v_width,
  input  logic [1:0]        cfg_pol,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_load,
  output logic              cfg_pending,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_empty,
  output logic              fifo_pop,
  output logic              line_req,
  output logic [CNT_W-1:0]  line_idx,
  output logic              underflow,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_hblank,
  output logic              vga_vblank,
  output logic [23:0]       vga_rgb
);

  localparam int unsigned IdxW = $clog2(DATA_W);

  localparam logic [IdxW-1:0] LastIdx1  = IdxW'(DATA_W - 1);
  localparam logic [IdxW-1:0] LastIdx8  = IdxW'(DATA_W / 8 - 1);
  localparam logic [IdxW-1:0] LastIdx16 = IdxW'(DATA_W / 16 - 1);
  localparam logic [IdxW-1:0] LastIdx32 = IdxW'(DATA_W / 32 - 1);

  logic [CNT_W-1:0] h_count_q, h_count_d, v_count_q, v_count_d;
  logic [CNT_W-1:0] h_total_q, h_sync_q, h_start_q, h_width_q;
  logic [CNT_W-1:0] v_total_q, v_sync_q, v_start_q, v_width_q;
  logic [1:0]       pol_q, mode_q;
  logic             cfg_pending_q, cfg_pending_d;
  logic [IdxW-1:0]  pix_idx_q, pix_idx_d;
  logic             hsync_q, vsync_q, hblank_q, vblank_q;
  logic             hsync_d, vsync_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             line_req_q, line_req_d;
  logic [CNT_W-1:0] line_idx_q, line_idx_d;
  logic             underflow_q, underflow_d;

  logic             h_end, frame_end, apply_cfg;
  logic [CNT_W-1:0] nv;
  logic [CNT_W:0]   h_stop, v_stop;
  logic             hactive, vactive, pixel_en, line_end, pop_c, uf_set;
  logic [IdxW-1:0]  last_idx, bit_off;
  logic [23:0]      pix, rgb_pix;

  always_comb begin
    h_end     = (h_count_q == h_total_q);
    frame_end = h_end && (v_count_q == v_total_q);
    apply_cfg = frame_end && (cfg_pending_q || cfg_load);
    nv        = (v_count_q == v_total_q) ? '0 : v_count_q + CNT_W'(1);
    h_count_d = h_end ? '0 : h_count_q + CNT_W'(1);
    v_count_d = h_end ? nv : v_count_q;

    // Start+width sums carry an extra bit so a window touching the counter top still closes.
    h_stop   = {1'b0, h_start_q} + {1'b0, h_width_q};
    v_stop   = {1'b0, v_start_q} + {1'b0, v_width_q};
    hactive  = (h_count_q >= h_start_q) && ({1'b0, h_count_q} < h_stop);
    vactive  = (v_count_q >= v_start_q) && ({1'b0, v_count_q} < v_stop);
    pixel_en = hactive && vactive;
    // hblank_q/vblank_q hold the previous cycle's window, so this marks the first blank cycle.
    line_end = ~hblank_q && ~vblank_q && ~pixel_en;

    hsync_d = (h_count_q < h_sync_q) ~^ pol_q[1];
    vsync_d = (v_count_q < v_sync_q) ~^ pol_q[0];

    cfg_pending_d = apply_cfg ? 1'b0 : (cfg_pending_q || cfg_load);

    line_req_d = h_end && (nv >= v_start_q) && ({1'b0, nv} < v_stop);
    line_idx_d = line_req_d ? nv - v_start_q : line_idx_q;
  end

  always_comb begin
    last_idx = LastIdx1;
    bit_off  = pix_idx_q;
    unique case (mode_q)
      2'd0: begin last_idx = LastIdx1;  bit_off = pix_idx_q;      end
      2'd1: begin last_idx = LastIdx8;  bit_off = pix_idx_q << 3; end
      2'd2: begin last_idx = LastIdx16; bit_off = pix_idx_q << 4; end
      2'd3: begin last_idx = LastIdx32; bit_off = pix_idx_q << 5; end
    endcase
    pix = 24'(fifo_rdata >> bit_off);

    rgb_pix = '0;
    unique case (mode_q)
      2'd0: rgb_pix = {24{pix[0]}};
      2'd1: rgb_pix = {pix[7:5], pix[7:5], pix[7:6], pix[4:2], pix[4:2], pix[4:3],
                       {4{pix[1:0]}}};
      2'd2: rgb_pix = {pix[15:11], pix[15:13], pix[10:5], pix[10:9], pix[4:0], pix[4:2]};
      2'd3: rgb_pix = pix[23:0];
    endcase
  end

  always_comb begin
    pop_c     = 1'b0;
    uf_set    = 1'b0;
    rgb_d     = '0;
    pix_idx_d = pix_idx_q;
    if (pixel_en) begin
      if (!fifo_empty) begin
        rgb_d = rgb_pix;
        if (pix_idx_q == last_idx) begin
          pop_c     = 1'b1;
          pix_idx_d = '0;
        end else begin
          pix_idx_d = pix_idx_q + IdxW'(1);
        end
      end else begin
        uf_set = 1'b1;
      end
    end else if (line_end && (pix_idx_q != '0) && !fifo_empty) begin
      // Drop the partially consumed word so the next line starts word-aligned.
      pop_c     = 1'b1;
      pix_idx_d = '0;
    end
    if (frame_end) pix_idx_d = '0;
    underflow_d = (underflow_q && !cfg_load) || uf_set;
  end

  always_ff @(posedge vga_clk or negedge vga_reset_n) begin
    if (!vga_reset_n) begin
      h_count_q     <= '0;
      v_count_q     <= '0;
      h_total_q     <= CNT_W'(799);
      h_sync_q      <= CNT_W'(96);
      h_start_q     <= CNT_W'(144);
      h_width_q     <= CNT_W'(640);
      v_total_q     <= CNT_W'(524);
      v_sync_q      <= CNT_W'(2);
      v_start_q     <= CNT_W'(35);
      v_width_q     <= CNT_W'(480);
      pol_q         <= 2'b00;
      mode_q        <= 2'd0;
      cfg_pending_q <= 1'b0;
      pix_idx_q     <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      rgb_q         <= '0;
      line_req_q    <= 1'b0;
      line_idx_q    <= '0;
      underflow_q   <= 1'b0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      cfg_pending_q <= cfg_pending_d;
      pix_idx_q     <= pix_idx_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= ~hactive;
      vblank_q      <= ~vactive;
      rgb_q         <= rgb_d;
      line_req_q    <= line_req_d;
      line_idx_q    <= line_idx_d;
      underflow_q   <= underflow_d;
      if (apply_cfg) begin
        h_total_q <= cfg_h_total;
        h_sync_q  <= cfg_h_sync;
        h_start_q <= cfg_h_start;
        h_width_q <= cfg_h_width;
        v_total_q <= cfg_v_total;
        v_sync_q  <= cfg_v_sync;
        v_start_q <= cfg_v_start;
        v_width_q <= cfg_v_width;
        pol_q     <= cfg_pol;
        mode_q    <= cfg_mode;
      end
    end
  end

  assign cfg_pending = cfg_pending_q;
  assign fifo_pop    = pop_c;
  assign line_req    = line_req_q;
  assign line_idx    = line_idx_q;
  assign underflow   = underflow_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_hblank  = hblank_q;
  assign vga_vblank  = vblank_q;
  assign vga_rgb     = rgb_q;

endmodule
